vga_sync_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the master clock. Drives H_Sync/V_Sync to the connector and supplies the display-enable and pixel-coordinate bus consumed by the VGA draw stage (Disp_Ena, Val_Row, Val_Col). Also provides per-pixel and per-frame strobes so downstream logic can update state once per frame.

---
 rtl/vga_timing_pkg.sv | 44 ++++
 rtl/vga_sync_gen_if.sv | 32 +++
 rtl/vga_pixel_prescaler.sv | 36 +++
 rtl/vga_sync_gen.sv | 107 ++++++++++
 tb/tb_vga_sync_gen.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// VGA raster timing defaults and shared helpers for the sync generator.
package vga_timing_pkg;

   localparam int unsigned COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   // 640x480@60 Hz from a 100 MHz master clock
   localparam int unsigned CLK_DIV_DEF  = 4;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;

   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;
   localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

   // 0 = active-low syncs (standard VGA 640x480)
   localparam int unsigned SYNC_POL_DEF = 0;

   typedef enum logic {
      SYNC_ACTIVE_LOW  = 1'b0,
      SYNC_ACTIVE_HIGH = 1'b1
   } sync_pol_e;

   // Level to drive on a sync pin given whether the pulse is active.
   function automatic logic sync_level(input logic active, input sync_pol_e pol);
      return active ? logic'(pol) : ~logic'(pol);
   endfunction

   // Half-open window test lo <= c < hi.
   function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
      return (c >= lo) && (c < hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster output bus from the sync generator to the connector and draw stage.
interface vga_sync_gen_if;

   logic                   H_Sync_Out;
   logic                   V_Sync_Out;
   logic                   Disp_Ena_Out;
   vga_timing_pkg::coord_t Val_Row_Out;
   vga_timing_pkg::coord_t Val_Col_Out;
   logic                   Pixel_Tick_Out;
   logic                   Frame_Tick_Out;

   modport master (
      output H_Sync_Out,
      output V_Sync_Out,
      output Disp_Ena_Out,
      output Val_Row_Out,
      output Val_Col_Out,
      output Pixel_Tick_Out,
      output Frame_Tick_Out
   );

   modport slave (
      input H_Sync_Out,
      input V_Sync_Out,
      input Disp_Ena_Out,
      input Val_Row_Out,
      input Val_Col_Out,
      input Pixel_Tick_Out,
      input Frame_Tick_Out
   );

endinterface

// File: rtl/vga_pixel_prescaler.sv
// Divides the master clock down to the pixel rate.
// pixel_load marks the first master cycle of a pixel period (outputs latch the
// current coordinate); pixel_advance marks the last one (counters step).
// With CLK_DIV=1 both are high every cycle.
module vga_pixel_prescaler #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic Master_Clock_In,
   input  logic Reset_N_In,
   output logic pixel_load,
   output logic pixel_advance
);

   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] p_cnt;

   // Free-running 0..CLK_DIV-1 phase counter
   always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         p_cnt <= '0;
      end else if (p_cnt == P_LAST) begin
         p_cnt <= '0;
      end else begin
         p_cnt <= p_cnt + 1'b1;
      end
   end

   // Phase decodes
   always_comb begin
      pixel_load    = (p_cnt == '0);
      pixel_advance = (p_cnt == P_LAST);
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters, sync/enable decode and a single
// aligned output register stage feeding the connector and draw stage.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter int unsigned SYNC_POL = SYNC_POL_DEF
) (
   input  logic           Master_Clock_In,
   input  logic           Reset_N_In,
   vga_sync_gen_if.master Vga_Bus
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
   localparam coord_t H_ACT_END  = coord_t'(H_ACTIVE);
   localparam coord_t V_ACT_END  = coord_t'(V_ACTIVE);
   localparam coord_t HS_START   = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VS_START   = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);

   localparam sync_pol_e POL = (SYNC_POL != 0) ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;

   logic   pixel_load;
   logic   pixel_advance;
   coord_t h_cnt;
   coord_t v_cnt;

   logic   disp_d;
   logic   hs_active_d;
   logic   vs_active_d;
   logic   frame_d;

   vga_pixel_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .Master_Clock_In (Master_Clock_In),
      .Reset_N_In      (Reset_N_In),
      .pixel_load      (pixel_load),
      .pixel_advance   (pixel_advance)
   );

   // Raster position; h and v wrap together on the last pixel of the frame
   always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pixel_advance) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + 1'b1;
            end
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // Decode of the current (h,v) ahead of the output register
   always_comb begin
      disp_d      = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      hs_active_d = in_window(h_cnt, HS_START, HS_END);
      vs_active_d = in_window(v_cnt, VS_START, VS_END);
      frame_d     = (h_cnt == '0) && (v_cnt == V_ACT_END);
   end

   // Output register: coordinate and decodes latch together at the start of
   // each pixel period, so the first edge after reset already shows (0,0)
   // while the counters step at the end of the period.
   always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         Vga_Bus.H_Sync_Out     <= sync_level(1'b0, POL);
         Vga_Bus.V_Sync_Out     <= sync_level(1'b0, POL);
         Vga_Bus.Disp_Ena_Out   <= 1'b0;
         Vga_Bus.Val_Row_Out    <= '0;
         Vga_Bus.Val_Col_Out    <= '0;
         Vga_Bus.Pixel_Tick_Out <= 1'b0;
         Vga_Bus.Frame_Tick_Out <= 1'b0;
      end else begin
         Vga_Bus.Pixel_Tick_Out <= pixel_load;
         Vga_Bus.Frame_Tick_Out <= pixel_load && frame_d;
         if (pixel_load) begin
            Vga_Bus.H_Sync_Out   <= sync_level(hs_active_d, POL);
            Vga_Bus.V_Sync_Out   <= sync_level(vs_active_d, POL);
            Vga_Bus.Disp_Ena_Out <= disp_d;
            Vga_Bus.Val_Row_Out  <= h_cnt;
            Vga_Bus.Val_Col_Out  <= v_cnt;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default 640x480 timing, and a
// shrunken raster at CLK_DIV=1/active-high and CLK_DIV=4/active-low) checked
// every cycle against an arithmetic raster model plus directed expectations.
module tb_vga_sync_gen;

   // Shrunken raster: 15 pixels x 11 lines
   localparam int S_HA = 8;
   localparam int S_HF = 2;
   localparam int S_HS = 3;
   localparam int S_HB = 2;
   localparam int S_VA = 6;
   localparam int S_VF = 1;
   localparam int S_VS = 2;
   localparam int S_VB = 2;

   typedef struct {
      int div;
      int ha, hfp, hsw, hbp;
      int va, vfp, vsw, vbp;
      int pol;
   } cfg_t;

   logic  clk   = 1'b0;
   logic  rst_n = 1'b1;
   longint k    = 0;
   int    total = 0;
   int    bad   = 0;

   logic [24:0] got_a, got_b, got_c;

   always #5 clk = ~clk;

   vga_sync_gen_if bus_a ();
   vga_sync_gen_if bus_b ();
   vga_sync_gen_if bus_c ();

   vga_sync_gen dut_a (
      .Master_Clock_In (clk),
      .Reset_N_In      (rst_n),
      .Vga_Bus         (bus_a)
   );

   vga_sync_gen #(
      .CLK_DIV (1), .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
      .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB), .SYNC_POL (1)
   ) dut_b (
      .Master_Clock_In (clk),
      .Reset_N_In      (rst_n),
      .Vga_Bus         (bus_b)
   );

   vga_sync_gen #(
      .CLK_DIV (4), .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
      .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB), .SYNC_POL (0)
   ) dut_c (
      .Master_Clock_In (clk),
      .Reset_N_In      (rst_n),
      .Vga_Bus         (bus_c)
   );

   // Packed view {hs, vs, de, row, col, pixel_tick, frame_tick}
   assign got_a = {bus_a.H_Sync_Out, bus_a.V_Sync_Out, bus_a.Disp_Ena_Out, bus_a.Val_Row_Out,
                   bus_a.Val_Col_Out, bus_a.Pixel_Tick_Out, bus_a.Frame_Tick_Out};
   assign got_b = {bus_b.H_Sync_Out, bus_b.V_Sync_Out, bus_b.Disp_Ena_Out, bus_b.Val_Row_Out,
                   bus_b.Val_Col_Out, bus_b.Pixel_Tick_Out, bus_b.Frame_Tick_Out};
   assign got_c = {bus_c.H_Sync_Out, bus_c.V_Sync_Out, bus_c.Disp_Ena_Out, bus_c.Val_Row_Out,
                   bus_c.Val_Col_Out, bus_c.Pixel_Tick_Out, bus_c.Frame_Tick_Out};

   function automatic cfg_t cfg_of(input int idx);
      cfg_t c;
      if (idx == 0) begin
         c = '{div: 4, ha: 640, hfp: 16, hsw: 96, hbp: 48,
               va: 480, vfp: 10, vsw: 2, vbp: 33, pol: 0};
      end else begin
         c = '{div: (idx == 1) ? 1 : 4, ha: S_HA, hfp: S_HF, hsw: S_HS, hbp: S_HB,
               va: S_VA, vfp: S_VF, vsw: S_VS, vbp: S_VB, pol: (idx == 1) ? 1 : 0};
      end
      return c;
   endfunction

   // Expected outputs after kk rising edges since reset release (kk=0: in reset).
   function automatic logic [24:0] model(input cfg_t c, input longint kk);
      longint q, h, v, ht, vt;
      logic   on_lvl, hs, vs, de, pt, ft;
      logic [9:0] row, col;
      on_lvl = (c.pol != 0);
      if (kk == 0) return {~on_lvl, ~on_lvl, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
      ht  = c.ha + c.hfp + c.hsw + c.hbp;
      vt  = c.va + c.vfp + c.vsw + c.vbp;
      q   = (kk - 1) / c.div;
      pt  = ((kk - 1) % c.div) == 0;
      h   = q % ht;
      v   = (q / ht) % vt;
      de  = (h < c.ha) && (v < c.va);
      hs  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? on_lvl : ~on_lvl;
      vs  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? on_lvl : ~on_lvl;
      ft  = pt && (h == 0) && (v == c.va);
      row = h[9:0];
      col = v[9:0];
      return {hs, vs, de, row, col, pt, ft};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (k=%0d)", name, act, exp, k);
      end
   endtask

   // Edges since reset release, the model's only notion of time
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   // Per-cycle comparison of every instance against the model
   always @(negedge clk) begin
      check("raster_a", {7'd0, got_a}, {7'd0, model(cfg_of(0), k)});
      check("raster_b", {7'd0, got_b}, {7'd0, model(cfg_of(1), k)});
      check("raster_c", {7'd0, got_c}, {7'd0, model(cfg_of(2), k)});
   end

   // Directed stimulus and hand-computed expectations
   initial begin
      int de_cnt, hs_cnt, hs_first_row, vs_cnt, seen_corner, ft_cnt;
      int ft_b_first, ft_b_second;
      logic found;
      de_cnt = 0; hs_cnt = 0; hs_first_row = -1; vs_cnt = 0;
      seen_corner = 0; ft_cnt = 0; ft_b_first = -1; ft_b_second = -1;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_a", {7'd0, got_a}, {7'd0, {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0}});
      check("reset_b", {7'd0, got_b}, {7'd0, {1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0}});
      check("reset_c", {7'd0, got_c}, {7'd0, {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0}});
      #1 rst_n = 1'b1;

      // One full default line; the small rasters run many frames meanwhile
      for (int i = 1; i <= 3200; i++) begin
         @(negedge clk);
         if (i == 1) begin
            check("first_px_a", {7'd0, got_a}, {7'd0, {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b0}});
            check("first_px_b", {7'd0, got_b}, {7'd0, {1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 1'b0}});
         end
         if (i == 2) check("tick_gap_a", {31'd0, bus_a.Pixel_Tick_Out}, 32'd0);
         if (i == 5) check("second_px_a", {7'd0, got_a}, {7'd0, {1'b1, 1'b1, 1'b1, 10'd1, 10'd0, 1'b1, 1'b0}});
         if (i == 11) check("hsync_high_b", {7'd0, got_b}, {7'd0, {1'b1, 1'b0, 1'b0, 10'd10, 10'd0, 1'b1, 1'b0}});
         if (bus_a.Disp_Ena_Out) de_cnt++;
         if (!bus_a.H_Sync_Out) begin
            hs_cnt++;
            if (hs_first_row < 0) hs_first_row = int'(bus_a.Val_Row_Out);
         end
         if (i <= 660 && !bus_c.V_Sync_Out) vs_cnt++;
         if (i <= 660 && bus_c.Pixel_Tick_Out && bus_c.Val_Row_Out == 10'd8 && bus_c.Val_Col_Out == 10'd6)
            seen_corner++;
         if (i <= 2640 && bus_c.Frame_Tick_Out) ft_cnt++;
         if (bus_b.Frame_Tick_Out) begin
            if (ft_b_first < 0) ft_b_first = i;
            else if (ft_b_second < 0) ft_b_second = i;
         end
      end
      check("de_cycles_a", de_cnt, 32'd2560);
      check("hs_cycles_a", hs_cnt, 32'd384);
      check("hs_start_row_a", hs_first_row, 32'd656);
      check("vs_cycles_c", vs_cnt, 32'd120);
      check("blank_corner_once_c", seen_corner, 32'd1);
      check("frame_ticks_c", ft_cnt, 32'd4);
      check("frame_tick_first_b", ft_b_first, 32'd91);
      check("frame_period_b", ft_b_second - ft_b_first, 32'd165);

      @(negedge clk);
      check("line_wrap_a", {7'd0, got_a}, {7'd0, {1'b1, 1'b1, 1'b1, 10'd0, 10'd1, 1'b1, 1'b0}});

      // Corner wrap on the small CLK_DIV=4 raster
      found = 1'b0;
      for (int n = 0; n < 800 && !found; n++) begin
         @(negedge clk);
         if (bus_c.Pixel_Tick_Out && bus_c.Val_Row_Out == 10'd14 && bus_c.Val_Col_Out == 10'd10)
            found = 1'b1;
      end
      check("corner_reached_c", {31'd0, found}, 32'd1);
      repeat (4) @(negedge clk);
      check("corner_wrap_c", {7'd0, got_c}, {7'd0, {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b0}});

      // Reset asserted mid-line inside H sync
      found = 1'b0;
      for (int n = 0; n < 800 && !found; n++) begin
         @(negedge clk);
         if (bus_c.Pixel_Tick_Out && bus_c.Val_Row_Out == 10'd11 && bus_c.Val_Col_Out == 10'd3)
            found = 1'b1;
      end
      check("midline_reached_c", {31'd0, found}, 32'd1);
      check("in_hsync_c", {31'd0, bus_c.H_Sync_Out}, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_c", {7'd0, got_c}, {7'd0, {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0}});
      check("async_rst_b_hs", {31'd0, bus_b.H_Sync_Out}, 32'd0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("restart_c", {7'd0, got_c}, {7'd0, {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b0}});
      check("restart_a", {7'd0, got_a}, {7'd0, {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b0}});

      repeat (400) @(negedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
